// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU op codes, register-0 constant,
// EX control bundle with its bubble value, and the forwarding select encoding.
package id_ex_stage_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int ALU_W = 6;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [ALU_W-1:0] ALU_SLL  = 6'h00;
    localparam logic [ALU_W-1:0] ALU_LUI  = 6'h0f;
    localparam logic [ALU_W-1:0] ALU_ADD  = 6'h20;
    localparam logic [ALU_W-1:0] ALU_ADDU = 6'h21;
    localparam logic [ALU_W-1:0] ALU_SUBU = 6'h23;
    localparam logic [ALU_W-1:0] ALU_AND  = 6'h24;
    localparam logic [ALU_W-1:0] ALU_OR   = 6'h25;
    localparam logic [ALU_W-1:0] ALU_SLT  = 6'h2a;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src_imm;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] dst;
        logic [XLEN-1:0]  rs_data;
        logic [XLEN-1:0]  rt_data;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] sa;
        logic [ALU_W-1:0] alu_ctrl;
        ex_ctrl_t         ctrl;
    } ex_reg_t;

    function automatic logic [XLEN-1:0] fwd_mux(
        input fwd_sel_e        sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] exmem_val,
        input logic [XLEN-1:0] memwb_val
    );
        case (sel)
            FWD_EXMEM: return exmem_val;
            FWD_MEMWB: return memwb_val;
            default:   return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding select for one EX source register; EX/MEM wins over MEM/WB and
// register 0 is never forwarded since it always reads as zero.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_W-1:0] src,
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_dst,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] memwb_dst,
    output fwd_sel_e         sel
);

    always_comb begin
        sel = FWD_REG;
        if (FWD_EN) begin
            if (exmem_reg_write && (exmem_dst != REG_ZERO) && (exmem_dst == src)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_dst != REG_ZERO) && (memwb_dst == src)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and EX operand
// forwarding from EX/MEM and MEM/WB into the ALU inputs.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REG_W-1:0] id_sa,
    input  logic [ALU_W-1:0] id_alu_ctrl,
    input  logic             id_alu_src_imm,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_mem_to_reg,
    input  logic             exmem_reg_write,
    input  logic [REG_W-1:0] exmem_dst,
    input  logic [XLEN-1:0]  exmem_result,
    input  logic             memwb_reg_write,
    input  logic [REG_W-1:0] memwb_dst,
    input  logic [XLEN-1:0]  memwb_wdata,
    output logic             stall,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_a,
    output logic [XLEN-1:0]  ex_b,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [ALU_W-1:0] ex_alu_ctrl,
    output logic [REG_W-1:0] ex_sa,
    output logic [REG_W-1:0] ex_dst,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_mem_to_reg
);

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    ex_ctrl_t        id_ctrl;
    fwd_sel_e        sel_rs;
    fwd_sel_e        sel_rt;
    logic [XLEN-1:0] rs_fwd;
    logic [XLEN-1:0] rt_fwd;

    // A load in EX cannot feed its data to the instruction right behind it.
    always_comb begin
        stall = id_valid && ex_q.valid && ex_q.ctrl.mem_read && (ex_q.dst != REG_ZERO) &&
                ((id_uses_rs && (id_rs == ex_q.dst)) || (id_uses_rt && (id_rt == ex_q.dst)));
    end

    always_comb begin
        id_ctrl.reg_write   = id_reg_write;
        id_ctrl.mem_read    = id_mem_read;
        id_ctrl.mem_write   = id_mem_write;
        id_ctrl.mem_to_reg  = id_mem_to_reg;
        id_ctrl.alu_src_imm = id_alu_src_imm;
    end

    always_comb begin
        ex_d = '0;
        if (!flush && !stall) begin
            ex_d.valid    = id_valid;
            ex_d.pc       = id_pc;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.dst      = id_dst;
            ex_d.rs_data  = id_rs_data;
            ex_d.rt_data  = id_rt_data;
            ex_d.imm      = id_imm;
            ex_d.sa       = id_sa;
            ex_d.alu_ctrl = id_alu_ctrl;
            ex_d.ctrl     = id_valid ? id_ctrl : CTRL_BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    id_ex_stage_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rs (
        .src             (ex_q.rs),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .sel             (sel_rs)
    );

    id_ex_stage_fwd_unit #(.FWD_EN(FWD_EN)) u_fwd_rt (
        .src             (ex_q.rt),
        .exmem_reg_write (exmem_reg_write),
        .exmem_dst       (exmem_dst),
        .memwb_reg_write (memwb_reg_write),
        .memwb_dst       (memwb_dst),
        .sel             (sel_rt)
    );

    // Forwarded values are picked in the cycle the producer sits in EX/MEM or MEM/WB.
    always_comb begin
        rs_fwd = fwd_mux(sel_rs, ex_q.rs_data, exmem_result, memwb_wdata);
        rt_fwd = fwd_mux(sel_rt, ex_q.rt_data, exmem_result, memwb_wdata);
    end

    assign ex_a          = rs_fwd;
    assign ex_b          = ex_q.ctrl.alu_src_imm ? ex_q.imm : rt_fwd;
    assign ex_store_data = rt_fwd;
    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_sa         = ex_q.sa;
    assign ex_dst        = ex_q.dst;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a forwarding instance and a non-forwarding
// instance share stimulus; expected EX contents go through a scoreboard queue.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_sa;
    logic [5:0]  id_alu_ctrl;
    logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write;
    logic [4:0]  exmem_dst;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_dst;
    logic [31:0] memwb_wdata;

    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [5:0]  ex_alu_ctrl;
    logic [4:0]  ex_sa, ex_dst;

    logic        n_stall, n_valid, n_reg_write, n_mem_read, n_mem_write, n_mem_to_reg;
    logic [31:0] n_pc, n_a, n_b, n_store_data;
    logic [5:0]  n_alu_ctrl;
    logic [4:0]  n_sa, n_dst;

    always #5 clk = ~clk;

    id_ex_stage #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_sa(id_sa),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_wdata(memwb_wdata),
        .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_sa(ex_sa),
        .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    id_ex_stage #(.FWD_EN(1'b0)) dut_nofwd (
        .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_sa(id_sa),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_src_imm(id_alu_src_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_dst(exmem_dst), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_dst(memwb_dst), .memwb_wdata(memwb_wdata),
        .stall(n_stall), .ex_valid(n_valid), .ex_pc(n_pc), .ex_a(n_a), .ex_b(n_b),
        .ex_store_data(n_store_data), .ex_alu_ctrl(n_alu_ctrl), .ex_sa(n_sa),
        .ex_dst(n_dst), .ex_reg_write(n_reg_write), .ex_mem_read(n_mem_read),
        .ex_mem_write(n_mem_write), .ex_mem_to_reg(n_mem_to_reg)
    );

    typedef struct packed {
        logic        valid, rw, mr, mw, m2r;
        logic [4:0]  dst, sa;
        logic [5:0]  alu;
        logic [31:0] pc, a, b, sd, a0, b0, sd0;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // forwarding inputs planned for the next check cycle
    logic        p_xw, p_ww;
    logic [4:0]  p_xd, p_wd;
    logic [31:0] p_xr, p_wv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs, rt, dst,
                          input logic urs, urt, input logic [31:0] rsd, rtd, imm,
                          input logic [4:0] sa, input logic [5:0] alu,
                          input logic srci, rw, mr, mw, m2r);
        id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_dst = dst;
        id_uses_rs = urs; id_uses_rt = urt; id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm; id_sa = sa; id_alu_ctrl = alu; id_alu_src_imm = srci;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic set_plan(input logic xw, input logic [4:0] xd, input logic [31:0] xr,
                            input logic ww, input logic [4:0] wd, input logic [31:0] wv);
        p_xw = xw; p_xd = xd; p_xr = xr; p_ww = ww; p_wd = wd; p_wv = wv;
    endtask

    function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] d);
        if (p_xw && p_xd != 5'd0 && p_xd == r) return p_xr;
        if (p_ww && p_wd != 5'd0 && p_wd == r) return p_wv;
        return d;
    endfunction

    // Expected EX content once the current ID inputs are taken (or bubbled).
    task automatic expect_latch(input bit bubble);
        exp_t        e;
        logic [31:0] rt_f;
        e = '0;
        if (!bubble) begin
            e.valid = id_valid;
            e.rw    = id_valid & id_reg_write;
            e.mr    = id_valid & id_mem_read;
            e.mw    = id_valid & id_mem_write;
            e.m2r   = id_valid & id_mem_to_reg;
            e.dst   = id_dst;
            e.sa    = id_sa;
            e.alu   = id_alu_ctrl;
            e.pc    = id_pc;
            rt_f    = model_fwd(id_rt, id_rt_data);
            e.a     = model_fwd(id_rs, id_rs_data);
            e.sd    = rt_f;
            e.b     = (id_valid & id_alu_src_imm) ? id_imm : rt_f;
            e.a0    = id_rs_data;
            e.sd0   = id_rt_data;
            e.b0    = (id_valid & id_alu_src_imm) ? id_imm : id_rt_data;
        end
        sb.push_back(e);
    endtask

    task automatic apply_fwd();
        exmem_reg_write = p_xw; exmem_dst = p_xd; exmem_result = p_xr;
        memwb_reg_write = p_ww; memwb_dst = p_wd; memwb_wdata = p_wv;
    endtask

    task automatic check_ex(input string tag);
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed %0d entries expected >0", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(ex_valid),      32'(e.valid));
            chk({tag, "_rw"},    32'(ex_reg_write),  32'(e.rw));
            chk({tag, "_mr"},    32'(ex_mem_read),   32'(e.mr));
            chk({tag, "_mw"},    32'(ex_mem_write),  32'(e.mw));
            chk({tag, "_m2r"},   32'(ex_mem_to_reg), 32'(e.m2r));
            chk({tag, "_dst"},   32'(ex_dst),        32'(e.dst));
            chk({tag, "_sa"},    32'(ex_sa),         32'(e.sa));
            chk({tag, "_alu"},   32'(ex_alu_ctrl),   32'(e.alu));
            chk({tag, "_pc"},    ex_pc,              e.pc);
            chk({tag, "_a"},     ex_a,               e.a);
            chk({tag, "_b"},     ex_b,               e.b);
            chk({tag, "_sd"},    ex_store_data,      e.sd);
            chk({tag, "_nf_valid"}, 32'(n_valid),      32'(e.valid));
            chk({tag, "_nf_rw"},    32'(n_reg_write),  32'(e.rw));
            chk({tag, "_nf_mr"},    32'(n_mem_read),   32'(e.mr));
            chk({tag, "_nf_mw"},    32'(n_mem_write),  32'(e.mw));
            chk({tag, "_nf_m2r"},   32'(n_mem_to_reg), 32'(e.m2r));
            chk({tag, "_nf_dst"},   32'(n_dst),        32'(e.dst));
            chk({tag, "_nf_sa"},    32'(n_sa),         32'(e.sa));
            chk({tag, "_nf_alu"},   32'(n_alu_ctrl),   32'(e.alu));
            chk({tag, "_nf_pc"},    n_pc,              e.pc);
            chk({tag, "_nf_a"},     n_a,               e.a0);
            chk({tag, "_nf_b"},     n_b,               e.b0);
            chk({tag, "_nf_sd"},    n_store_data,      e.sd0);
        end
    endtask

    task automatic cycle_and_check(input string tag);
        @(posedge clk);
        #1;
        apply_fwd();
        #1;
        check_ex(tag);
    endtask

    task automatic recheck(input string tag);
        apply_fwd();
        #1;
        check_ex(tag);
    endtask

    task automatic chk_stall(input string tag, input logic expv);
        chk({tag, "_stall"},    32'(stall),   32'(expv));
        chk({tag, "_nf_stall"}, 32'(n_stall), 32'(expv));
    endtask

    initial begin
        // reset with garbage in ID
        rst = 1'b1;
        flush = 1'b0;
        set_id(1'b1, 32'hFFFF_FFFC, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
               32'hFFFF_0000, 5'd31, ALU_SLT, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        set_plan(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        apply_fwd();
        repeat (2) @(posedge clk);
        #1;
        chk_stall("reset", 1'b0);
        expect_latch(1'b1);
        cycle_and_check("reset");
        chk_stall("reset2", 1'b0);
        rst = 1'b0;

        // sub $4,$3,$5 with $3 in EX/MEM
        set_id(1'b1, 32'h100, 5'd3, 5'd5, 5'd4, 1'b1, 1'b1, 32'hDEAD, 32'h7,
               32'h0, 5'd5, ALU_SUBU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_plan(1'b1, 5'd3, 32'h10, 1'b0, 5'd0, 32'h0);
        expect_latch(1'b0);
        cycle_and_check("exmem_fwd");

        // priority between EX/MEM and MEM/WB
        set_plan(1'b1, 5'd3, 32'h20, 1'b1, 5'd3, 32'h30);
        expect_latch(1'b0);
        cycle_and_check("prio_exmem");
        set_plan(1'b0, 5'd3, 32'h20, 1'b1, 5'd3, 32'h30);
        expect_latch(1'b0);
        recheck("prio_memwb");

        // register 0 never forwarded
        set_id(1'b1, 32'h104, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 32'h0, 32'h0,
               32'h0, 5'd0, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_plan(1'b1, 5'd0, 32'h99, 1'b1, 5'd0, 32'h77);
        expect_latch(1'b0);
        cycle_and_check("reg0");

        // lw $7,0($1) then addu $8,$2,$7: one stall, bubble, then MEM/WB forward
        set_id(1'b1, 32'h108, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 32'h1000, 32'h0,
               32'h0, 5'd0, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        set_plan(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_latch(1'b0);
        cycle_and_check("lw");
        set_id(1'b1, 32'h10C, 5'd2, 5'd7, 5'd8, 1'b1, 1'b1, 32'h2222, 32'hBAD,
               32'h0, 5'd0, ALU_ADDU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk_stall("loaduse", 1'b1);
        set_plan(1'b1, 5'd7, 32'h1000, 1'b0, 5'd0, 32'h0);
        expect_latch(1'b1);
        cycle_and_check("loaduse_bubble");
        chk_stall("loaduse_after", 1'b0);
        set_plan(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hABCD);
        expect_latch(1'b0);
        cycle_and_check("loaduse_fwd");

        // flush coinciding with a load-use stall
        set_id(1'b1, 32'h110, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 32'h1000, 32'h0,
               32'h0, 5'd0, ALU_ADD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        set_plan(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_latch(1'b0);
        cycle_and_check("lw2");
        set_id(1'b1, 32'h114, 5'd9, 5'd7, 5'd0, 1'b1, 1'b1, 32'h300, 32'h44,
               32'h4, 5'd0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        chk_stall("flush_stall", 1'b1);
        expect_latch(1'b1);
        cycle_and_check("flush_stall_bubble");
        flush = 1'b0;

        // sw $5,4($6) with $5 forwarded from EX/MEM
        set_id(1'b1, 32'h118, 5'd6, 5'd5, 5'd0, 1'b1, 1'b1, 32'h100, 32'h33,
               32'h4, 5'd0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_stall("sw", 1'b0);
        set_plan(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
        expect_latch(1'b0);
        cycle_and_check("sw_imm");

        // flush alone
        set_id(1'b1, 32'h11C, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2,
               32'h0, 5'd0, ALU_ADDU, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        set_plan(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_latch(1'b1);
        cycle_and_check("flush");
        flush = 1'b0;

        // invalid ID: fields latched, controls gated
        set_id(1'b0, 32'h120, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22,
               32'h0, 5'd3, ALU_SLL, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_latch(1'b0);
        cycle_and_check("id_invalid");

        // asynchronous reset mid-cycle drops EX contents
        set_id(1'b1, 32'h124, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h11, 32'h22,
               32'h0, 5'd0, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_latch(1'b0);
        cycle_and_check("pre_rst");
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(ex_valid), 32'd0);
        chk("async_rst_rw",    32'(ex_reg_write), 32'd0);
        chk("async_rst_pc",    ex_pc, 32'd0);
        chk("async_rst_a",     ex_a, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus execute-operand logic for the 5-stage MIPS pipeline. Sits directly upstream of the ALU.
- Latches decoded instruction fields and controls from ID each cycle.
- Drives the ALU `a`/`b`/`alu_ctrl`/`sa` inputs, resolving RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, stalls IF/ID and injects a bubble.

Parameters:
- FWD_EN, 1, 1 = forwarding enabled; 0 = operands always taken from latched register-file data (hazards then fall to software/NOPs).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  branch/jump redirect; next EX content becomes a bubble
- id_valid  input  1  ID holds a real instruction
- id_pc  input  32  PC of ID instruction
- id_rs, id_rt  input  5 each  source register numbers
- id_dst  input  5  destination register (rd or rt, already selected)
- id_uses_rs, id_uses_rt  input  1 each  instruction reads rs/rt
- id_rs_data, id_rt_data  input  32 each  register-file read data
- id_imm  input  32  extended immediate
- id_sa  input  5  shift amount
- id_alu_ctrl  input  6  ALU op code (shared op constants)
- id_alu_src_imm  input  1  b operand = immediate
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each  controls
- exmem_reg_write  input  1  EX/MEM writes a register
- exmem_dst  input  5  EX/MEM destination
- exmem_result  input  32  EX/MEM ALU result
- memwb_reg_write  input  1  MEM/WB writes a register
- memwb_dst  input  5  MEM/WB destination
- memwb_wdata  input  32  final writeback data
- stall  output  1  hold PC and IF/ID (combinational)
- ex_valid  output  1  EX holds a real instruction
- ex_pc  output  32
- ex_a, ex_b  output  32 each  ALU operands (combinational from registered state and forward inputs)
- ex_store_data  output  32  forwarded rt value for stores
- ex_alu_ctrl  output  6;  ex_sa  output  5;  ex_dst  output  5
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each

Behaviour:
- **Reset:** all registered state cleared; ex_valid=0, all controls 0, ex_pc/ex_dst/ex_alu_ctrl/ex_sa=0, latched data 0, so ex_a=ex_b=ex_store_data=0 while memwb/exmem reg_write are 0. Reset asserted mid-operation discards the EX contents immediately.
- **Load-use hazard (combinational):**
  - stall=1 when ex_valid & ex_mem_read & ex_dst!=0 & ((id_uses_rs & id_rs==ex_dst) | (id_uses_rt & id_rt==ex_dst)) & id_valid.
  - stall is independent of FWD_EN.
- **Register update each rising edge:**
  - flush=1: bubble (valid and all controls 0, fields don't-care, held 0).
  - else stall=1: bubble.
  - else: latch all id_* fields; ex_valid=id_valid; controls gated by id_valid.
  - flush and stall both set: bubble; stall has no further effect.
- **Forwarding (FWD_EN=1), per source r in {rs, rt}:**
  - If exmem_reg_write & exmem_dst!=0 & exmem_dst==r: use exmem_result.
  - Else if memwb_reg_write & memwb_dst!=0 & memwb_dst==r: use memwb_wdata.
  - Else use the latched register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- **Operand selection:**
  - ex_a = forwarded rs.
  - ex_b = id_alu_src_imm-latched ? latched imm : forwarded rt.
  - ex_store_data = forwarded rt always.
- **Latency:** one cycle ID→EX. Forwarded operands are valid in the same cycle as the producer result is present in EX/MEM or MEM/WB.
- The register file is not write-through; same-cycle WB→ID is covered by MEM/WB forwarding only while the consumer is in EX.

Decomposition:
- Shared include holds:
  - ALU op codes (add/addu/subu/and/or/slt/lui/sll)
  - register-0 constant
  - bubble control constant
- One natural sub-module: **fwd_unit**, combinational. It takes the source register plus the EX/MEM and MEM/WB write ports and produces a 2-bit select. It is instantiated twice.
- Hazard detection stays in id_ex_stage.

Test Plan:
- **Reset:** hold rst=1 with garbage id_* inputs → ex_valid=0, all ex_* controls 0, stall=0; release → first clean latch next edge.
- **EX/MEM forward:** addu $3=$1+$2 in EX/MEM (exmem_dst=3, exmem_result=0x10), ID `sub $4,$3,$5` with id_rs_data=0xDEAD → next cycle ex_a=0x10.
- **Priority:** exmem_dst=3 result 0x20 and memwb_dst=3 wdata 0x30 → ex_a=0x20. With exmem_reg_write=0 → 0x30. With dst=0 on both → latched 0x0 register-file value.
- **Load-use:** EX holds lw dst=7, ID uses rt=7 → stall=1 for exactly one cycle, next ex_valid=0. Following cycle: instruction latched, ex_b=memwb_wdata.
- **Flush during stall:** flush=1 with stall=1 → bubble; ex_reg_write=0, ex_mem_write=0.
- **Immediate/store:** sw with id_alu_src_imm=1, imm=0x4, rt forwarded 0x55 from EX/MEM → ex_b=0x4, ex_store_data=0x55. With FWD_EN=0 → ex_store_data=latched id_rt_data.
